// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the processor memory arbiter: FSM encodings and defaults.
package mem_arbiter_pkg;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned I_ADDR_W       = 16;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned WE_W           = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data ports onto one single-port memory,
// with at most one read in flight and a bound on how long a fetch can starve.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_oe,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic [31:0] d_addr,
    input  logic        d_oe,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_ready,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    state_t                state, state_nxt;
    logic                  i_pend, i_pend_nxt;
    logic [I_ADDR_W-1:0]   i_pend_addr, i_pend_addr_nxt;
    logic [CNT_W-1:0]      starve_cnt, starve_cnt_nxt;
    logic [DATA_W-1:0]     i_hold, i_hold_nxt;
    logic [DATA_W-1:0]     d_hold, d_hold_nxt;

    logic                  free;
    logic                  fetch_valid;
    logic [I_ADDR_W-1:0]   fetch_addr;
    logic                  data_wins;
    logic                  data_gnt;
    logic                  fetch_gnt;

    // State, pending fetch, starvation counter and read-data hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            i_pend      <= 1'b0;
            i_pend_addr <= '0;
            starve_cnt  <= '0;
            i_hold      <= '0;
            d_hold      <= '0;
        end else begin
            state       <= state_nxt;
            i_pend      <= i_pend_nxt;
            i_pend_addr <= i_pend_addr_nxt;
            starve_cnt  <= starve_cnt_nxt;
            i_hold      <= i_hold_nxt;
            d_hold      <= d_hold_nxt;
        end
    end

    // Arbitration, memory request, return steering and next-state logic.
    always_comb begin
        state_nxt       = state;
        i_pend_nxt      = i_pend;
        i_pend_addr_nxt = i_pend_addr;
        starve_cnt_nxt  = starve_cnt;
        i_hold_nxt      = i_hold;
        d_hold_nxt      = d_hold;

        // The return cycle of an outstanding read is also an issue slot.
        free        = (state == IDLE) || m_rvalid;
        fetch_valid = i_oe || i_pend;
        fetch_addr  = i_oe ? i_addr : i_pend_addr;
        data_wins   = d_oe && !((starve_cnt == CNT_W'(STARVE_MAX)) && fetch_valid);

        m_req   = !rst && free && (d_oe || fetch_valid);
        m_addr  = data_wins ? d_addr : {16'h0, fetch_addr};
        m_we    = data_wins ? d_we : '0;
        m_wdata = data_wins ? d_wdata : '0;

        d_ready   = m_req && data_wins && m_gnt;
        data_gnt  = d_ready;
        fetch_gnt = m_req && !data_wins && m_gnt;

        i_valid = !rst && m_rvalid && (state == IBUSY);
        d_valid = !rst && m_rvalid && (state == DBUSY);
        i_rdata = i_valid ? m_rdata : i_hold;
        d_rdata = d_valid ? m_rdata : d_hold;
        if (i_valid) i_hold_nxt = m_rdata;
        if (d_valid) d_hold_nxt = m_rdata;

        // Stores finish on grant; only reads leave a transaction outstanding.
        if (free) begin
            state_nxt = IDLE;
            if (data_gnt && (d_we == '0)) state_nxt = DBUSY;
            else if (fetch_gnt)           state_nxt = IBUSY;
        end

        // A newer fetch request always replaces an older pending one.
        if (fetch_gnt) begin
            i_pend_nxt = 1'b0;
        end else if (i_oe) begin
            i_pend_nxt      = 1'b1;
            i_pend_addr_nxt = i_addr;
        end

        if (fetch_gnt || !fetch_valid) begin
            starve_cnt_nxt = '0;
        end else if (data_gnt && (starve_cnt != '1)) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

endmodule
